lc3_datapath: RTL and testbench



---
 rtl/lc3_pkg.sv | 48 ++++
 rtl/lc3_regfile.sv | 35 +++
 rtl/lc3_datapath.sv | 208 ++++++++++++++++++++
 tb/tb_lc3_datapath.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lc3_pkg : shared mux/ALU encodings and device addresses for LC-3   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package lc3_pkg;

    typedef enum logic [1:0] {
        ALUK_ADD  = 2'b00,
        ALUK_AND  = 2'b01,
        ALUK_NOT  = 2'b10,
        ALUK_PASS = 2'b11
    } aluk_e;

    typedef enum logic [1:0] {
        BUS_PC     = 2'b00,
        BUS_MARMUX = 2'b01,
        BUS_ALU    = 2'b10,
        BUS_MDR    = 2'b11
    } bus_sel_e;

    typedef enum logic [1:0] {
        PCMUX_INC   = 2'b00,
        PCMUX_BUS   = 2'b01,
        PCMUX_ADDER = 2'b10,
        PCMUX_HOLD  = 2'b11
    } pcmux_e;

    typedef enum logic [1:0] {
        ADDR2_ZERO  = 2'b00,
        ADDR2_OFF6  = 2'b01,
        ADDR2_OFF9  = 2'b10,
        ADDR2_OFF11 = 2'b11
    } addr2mux_e;

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    // True for any address decoded to a device register rather than memory
    function automatic logic is_dev_addr(input logic [15:0] addr);
        return (addr == ADDR_KBSR) || (addr == ADDR_KBDR) ||
               (addr == ADDR_DSR)  || (addr == ADDR_DDR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lc3_regfile : 8x16 registers, two async reads, one sync write      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module lc3_regfile (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [2:0]       waddr,
    input  logic [15:0]      wdata,
    input  logic [2:0]       raddr_a,
    input  logic [2:0]       raddr_b,
    output logic [15:0]      rdata_a,
    output logic [15:0]      rdata_b,
    output logic [7:0][15:0] regs
);

    logic [7:0][15:0] r_regs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs <= '0;
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Reads see the pre-write value when a write targets the same register
    assign rdata_a = r_regs[raddr_a];
    assign rdata_b = r_regs[raddr_b];
    assign regs    = r_regs;

endmodule
`default_nettype wire

// File: rtl/lc3_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lc3_datapath : LC-3 datapath with memory and display registers     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module lc3_datapath
    import lc3_pkg::*;
#(
    parameter logic [15:0] PC_RESET = 16'h3000,
    parameter int          MEM_AW   = 12,
    parameter              MEM_INIT = ""
) (
    input  logic        i_Clk,
    input  logic        reset_,
    input  logic [1:0]  ALUK,
    input  logic [1:0]  BUS_SEL,
    input  logic        LD_BUS,
    input  logic        RW,
    input  logic        MIO_EN,
    input  logic [2:0]  DR,
    input  logic [2:0]  SR1_SEL,
    input  logic [2:0]  SR2_SEL,
    input  logic [1:0]  PCMUX_SEL,
    input  logic        SR2MUX_SEL,
    input  logic        MARMUX_SEL,
    input  logic        ADDR1MUX_SEL,
    input  logic [1:0]  ADDR2MUX_SEL,
    input  logic        LD_CC,
    input  logic        LD_REG,
    input  logic        LD_IR,
    input  logic        LD_PC,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        LD_DSR_EXT,
    input  logic [15:0] dsr_ext,
    output logic        R,
    output logic [15:0] ir,
    output logic [2:0]  nzp,
    output logic [15:0] ddr,
    output logic [15:0] dsr,
    output logic [15:0] debug_mar,
    output logic [15:0] debug_mdr,
    output logic [15:0] debug_memory,
    output logic [15:0] debug_bus,
    output logic [15:0] debug_pc,
    output logic [15:0] debug_ddr,
    output logic [15:0] debug_dsr,
    output logic [15:0] debug_r0,
    output logic [15:0] debug_r1,
    output logic [15:0] debug_r2,
    output logic [15:0] debug_r3,
    output logic [15:0] debug_r4,
    output logic [15:0] debug_r5,
    output logic [15:0] debug_r6,
    output logic [15:0] debug_r7
);

    logic [15:0] r_pc, r_ir, r_mar, r_mdr, r_ddr, r_dsr;
    logic [2:0]  r_nzp;
    logic [15:0] r_mem [0:(1<<MEM_AW)-1];

    logic [15:0]       w_sr1, w_sr2, w_alu_b, w_alu;
    logic [15:0]       w_addr1, w_addr2, w_adder, w_marmux;
    logic [15:0]       w_bus_src, w_bus, w_rdata, w_mdr_in, w_pc_next;
    logic [MEM_AW-1:0] w_mem_idx;
    logic              w_store;
    logic [7:0][15:0]  w_regs;

    lc3_regfile u_regfile (
        .clk     (i_Clk),
        .rst     (reset_),
        .we      (LD_REG),
        .waddr   (DR),
        .wdata   (w_bus),
        .raddr_a (SR1_SEL),
        .raddr_b (SR2_SEL),
        .rdata_a (w_sr1),
        .rdata_b (w_sr2),
        .regs    (w_regs)
    );

    assign w_alu_b = SR2MUX_SEL ? {{11{r_ir[4]}}, r_ir[4:0]} : w_sr2;

    always_comb begin
        w_alu = w_sr1;
        case (aluk_e'(ALUK))
            ALUK_ADD:  w_alu = w_sr1 + w_alu_b;
            ALUK_AND:  w_alu = w_sr1 & w_alu_b;
            ALUK_NOT:  w_alu = ~w_sr1;
            ALUK_PASS: w_alu = w_sr1;
            default:   w_alu = w_sr1;
        endcase
    end

    assign w_addr1 = ADDR1MUX_SEL ? w_sr1 : r_pc;

    always_comb begin
        w_addr2 = 16'h0000;
        case (addr2mux_e'(ADDR2MUX_SEL))
            ADDR2_ZERO:  w_addr2 = 16'h0000;
            ADDR2_OFF6:  w_addr2 = {{10{r_ir[5]}},  r_ir[5:0]};
            ADDR2_OFF9:  w_addr2 = {{7{r_ir[8]}},   r_ir[8:0]};
            ADDR2_OFF11: w_addr2 = {{5{r_ir[10]}},  r_ir[10:0]};
            default:     w_addr2 = 16'h0000;
        endcase
    end

    assign w_adder  = w_addr1 + w_addr2;
    assign w_marmux = MARMUX_SEL ? w_adder : {8'h00, r_ir[7:0]};

    always_comb begin
        w_bus_src = r_pc;
        case (bus_sel_e'(BUS_SEL))
            BUS_PC:     w_bus_src = r_pc;
            BUS_MARMUX: w_bus_src = w_marmux;
            BUS_ALU:    w_bus_src = w_alu;
            BUS_MDR:    w_bus_src = r_mdr;
            default:    w_bus_src = r_pc;
        endcase
    end

    assign w_bus = LD_BUS ? w_bus_src : 16'h0000;

    // Device registers shadow memory; the keyboard slots read as zero
    assign w_mem_idx = r_mar[MEM_AW-1:0];

    always_comb begin
        w_rdata = r_mem[w_mem_idx];
        case (r_mar)
            ADDR_DSR:             w_rdata = r_dsr;
            ADDR_DDR:             w_rdata = r_ddr;
            ADDR_KBSR, ADDR_KBDR: w_rdata = 16'h0000;
            default:              w_rdata = r_mem[w_mem_idx];
        endcase
    end

    assign w_mdr_in = (MIO_EN && !RW) ? w_rdata : w_bus;
    assign w_store  = MIO_EN && RW;

    always_comb begin
        w_pc_next = r_pc;
        case (pcmux_e'(PCMUX_SEL))
            PCMUX_INC:   w_pc_next = r_pc + 16'h0001;
            PCMUX_BUS:   w_pc_next = w_bus;
            PCMUX_ADDER: w_pc_next = w_adder;
            PCMUX_HOLD:  w_pc_next = r_pc;
            default:     w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!reset_ && w_store && !is_dev_addr(r_mar)) begin
            r_mem[w_mem_idx] <= r_mdr;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (reset_) begin
            r_pc  <= PC_RESET;
            r_ir  <= 16'h0000;
            r_mar <= 16'h0000;
            r_mdr <= 16'h0000;
            r_ddr <= 16'h0000;
            r_dsr <= 16'h8000;
            r_nzp <= 3'b010;
        end else begin
            if (LD_PC)  r_pc  <= w_pc_next;
            if (LD_IR)  r_ir  <= w_bus;
            if (LD_MAR) r_mar <= w_bus;
            if (LD_MDR) r_mdr <= w_mdr_in;
            if (w_store && (r_mar == ADDR_DDR)) r_ddr <= r_mdr;
            // The UART side owns DSR whenever both try to write it
            if (LD_DSR_EXT) begin
                r_dsr <= dsr_ext;
            end else if (w_store && (r_mar == ADDR_DSR)) begin
                r_dsr <= r_mdr;
            end
            if (LD_CC) begin
                if (w_bus[15])            r_nzp <= 3'b100;
                else if (w_bus == 16'h0)  r_nzp <= 3'b010;
                else                      r_nzp <= 3'b001;
            end
        end
    end

    assign R            = MIO_EN;
    assign ir           = r_ir;
    assign nzp          = r_nzp;
    assign ddr          = r_ddr;
    assign dsr          = r_dsr;
    assign debug_mar    = r_mar;
    assign debug_mdr    = r_mdr;
    assign debug_memory = w_rdata;
    assign debug_bus    = w_bus;
    assign debug_pc     = r_pc;
    assign debug_ddr    = r_ddr;
    assign debug_dsr    = r_dsr;
    assign debug_r0     = w_regs[0];
    assign debug_r1     = w_regs[1];
    assign debug_r2     = w_regs[2];
    assign debug_r3     = w_regs[3];
    assign debug_r4     = w_regs[4];
    assign debug_r5     = w_regs[5];
    assign debug_r6     = w_regs[6];
    assign debug_r7     = w_regs[7];

endmodule
`default_nettype wire

// File: tb/tb_lc3_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lc3_datapath : directed + random checks against a bench model   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_lc3_datapath;

    logic        i_Clk = 1'b0;
    logic        reset_;
    logic [1:0]  ALUK, BUS_SEL, PCMUX_SEL, ADDR2MUX_SEL;
    logic        LD_BUS, RW, MIO_EN, SR2MUX_SEL, MARMUX_SEL, ADDR1MUX_SEL;
    logic [2:0]  DR, SR1_SEL, SR2_SEL;
    logic        LD_CC, LD_REG, LD_IR, LD_PC, LD_MAR, LD_MDR, LD_DSR_EXT;
    logic [15:0] dsr_ext;
    logic        R;
    logic [15:0] ir, ddr, dsr;
    logic [2:0]  nzp;
    logic [15:0] debug_mar, debug_mdr, debug_memory, debug_bus, debug_pc, debug_ddr, debug_dsr;
    logic [15:0] debug_r0, debug_r1, debug_r2, debug_r3, debug_r4, debug_r5, debug_r6, debug_r7;

    always #5 i_Clk = ~i_Clk;

    lc3_datapath dut (
        .i_Clk(i_Clk), .reset_(reset_), .ALUK(ALUK), .BUS_SEL(BUS_SEL), .LD_BUS(LD_BUS),
        .RW(RW), .MIO_EN(MIO_EN), .DR(DR), .SR1_SEL(SR1_SEL), .SR2_SEL(SR2_SEL),
        .PCMUX_SEL(PCMUX_SEL), .SR2MUX_SEL(SR2MUX_SEL), .MARMUX_SEL(MARMUX_SEL),
        .ADDR1MUX_SEL(ADDR1MUX_SEL), .ADDR2MUX_SEL(ADDR2MUX_SEL), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_IR(LD_IR), .LD_PC(LD_PC), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .LD_DSR_EXT(LD_DSR_EXT), .dsr_ext(dsr_ext), .R(R), .ir(ir), .nzp(nzp),
        .ddr(ddr), .dsr(dsr), .debug_mar(debug_mar), .debug_mdr(debug_mdr),
        .debug_memory(debug_memory), .debug_bus(debug_bus), .debug_pc(debug_pc),
        .debug_ddr(debug_ddr), .debug_dsr(debug_dsr), .debug_r0(debug_r0),
        .debug_r1(debug_r1), .debug_r2(debug_r2), .debug_r3(debug_r3), .debug_r4(debug_r4),
        .debug_r5(debug_r5), .debug_r6(debug_r6), .debug_r7(debug_r7)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit model_ok = 1'b0;

    // Architectural state of the reference model
    logic [15:0] m_pc, m_ir, m_mar, m_mdr, m_ddr, m_dsr;
    logic [2:0]  m_nzp;
    logic [15:0] m_r [0:7];
    logic [15:0] m_mem [0:4095];
    bit          m_memv [0:4095];
    logic [15:0] m_a, m_b, m_alu, m_add, m_marmux, m_rd, m_bus;
    bit          m_rdv;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sx(input logic [15:0] v, input int n);
        logic [15:0] mask;
        mask = 16'hFFFF >> (16 - n);
        return v[n-1] ? (v | ~mask) : (v & mask);
    endfunction

    task automatic model_comb();
        logic [15:0] off, src;
        m_a = m_r[SR1_SEL];
        m_b = SR2MUX_SEL ? sx(m_ir, 5) : m_r[SR2_SEL];
        case (ALUK)
            2'd0:    m_alu = m_a + m_b;
            2'd1:    m_alu = m_a & m_b;
            2'd2:    m_alu = ~m_a;
            default: m_alu = m_a;
        endcase
        case (ADDR2MUX_SEL)
            2'd0:    off = 16'h0000;
            2'd1:    off = sx(m_ir, 6);
            2'd2:    off = sx(m_ir, 9);
            default: off = sx(m_ir, 11);
        endcase
        m_add    = (ADDR1MUX_SEL ? m_a : m_pc) + off;
        m_marmux = MARMUX_SEL ? m_add : {8'h00, m_ir[7:0]};
        m_rdv    = 1'b1;
        if (m_mar == 16'hFE04)      m_rd = m_dsr;
        else if (m_mar == 16'hFE06) m_rd = m_ddr;
        else if (m_mar == 16'hFE00 || m_mar == 16'hFE02) m_rd = 16'h0000;
        else begin
            m_rd  = m_mem[m_mar[11:0]];
            m_rdv = m_memv[m_mar[11:0]];
        end
        case (BUS_SEL)
            2'd0:    src = m_pc;
            2'd1:    src = m_marmux;
            2'd2:    src = m_alu;
            default: src = m_mdr;
        endcase
        m_bus = LD_BUS ? src : 16'h0000;
    endtask

    task automatic model_step();
        bit store;
        logic [15:0] a, old_mdr;
        model_comb();
        if (reset_) begin
            m_pc = 16'h3000; m_ir = 0; m_mar = 0; m_mdr = 0; m_ddr = 0;
            m_dsr = 16'h8000; m_nzp = 3'b010;
            for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
            model_ok = 1'b1;
        end else begin
            store = MIO_EN && RW;
            a = m_mar;
            old_mdr = m_mdr;
            if (store && a == 16'hFE06) m_ddr = old_mdr;
            if (LD_DSR_EXT) m_dsr = dsr_ext;
            else if (store && a == 16'hFE04) m_dsr = old_mdr;
            if (store && a != 16'hFE00 && a != 16'hFE02 && a != 16'hFE04 && a != 16'hFE06) begin
                m_mem[a[11:0]]  = old_mdr;
                m_memv[a[11:0]] = 1'b1;
            end
            if (LD_MDR) m_mdr = (MIO_EN && !RW) ? m_rd : m_bus;
            if (LD_MAR) m_mar = m_bus;
            if (LD_IR)  m_ir  = m_bus;
            if (LD_PC) begin
                case (PCMUX_SEL)
                    2'd0:    m_pc = m_pc + 16'h0001;
                    2'd1:    m_pc = m_bus;
                    2'd2:    m_pc = m_add;
                    default: m_pc = m_pc;
                endcase
            end
            if (LD_REG) m_r[DR] = m_bus;
            if (LD_CC)  m_nzp = m_bus[15] ? 3'b100 : (m_bus == 16'h0000 ? 3'b010 : 3'b001);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) m_memv[i] = 1'b0;
        forever begin
            @(posedge i_Clk);
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge i_Clk);
            if (model_ok) begin
                model_comb();
                chk("pc", debug_pc, m_pc);
                chk("ir", ir, m_ir);
                chk("mar", debug_mar, m_mar);
                chk("mdr", debug_mdr, m_mdr);
                chk("ddr", ddr, m_ddr);
                chk("debug_ddr", debug_ddr, m_ddr);
                chk("dsr", dsr, m_dsr);
                chk("debug_dsr", debug_dsr, m_dsr);
                chk("nzp", {13'h0, nzp}, {13'h0, m_nzp});
                chk("r_ready", {15'h0, R}, {15'h0, MIO_EN});
                chk("bus", debug_bus, m_bus);
                chk("r0", debug_r0, m_r[0]);
                chk("r1", debug_r1, m_r[1]);
                chk("r2", debug_r2, m_r[2]);
                chk("r3", debug_r3, m_r[3]);
                chk("r4", debug_r4, m_r[4]);
                chk("r5", debug_r5, m_r[5]);
                chk("r6", debug_r6, m_r[6]);
                chk("r7", debug_r7, m_r[7]);
                if (m_rdv) chk("memory", debug_memory, m_rd);
            end
        end
    end

    task automatic idle();
        reset_ = 0; ALUK = 0; BUS_SEL = 0; PCMUX_SEL = 0; ADDR2MUX_SEL = 0;
        LD_BUS = 0; RW = 0; MIO_EN = 0; SR2MUX_SEL = 0; MARMUX_SEL = 0; ADDR1MUX_SEL = 0;
        DR = 0; SR1_SEL = 0; SR2_SEL = 0; LD_CC = 0; LD_REG = 0; LD_IR = 0; LD_PC = 0;
        LD_MAR = 0; LD_MDR = 0; LD_DSR_EXT = 0; dsr_ext = 0;
    endtask

    task automatic cyc();
        @(posedge i_Clk);
        #1;
    endtask

    // Bus carries R[r] through the ALU; caller adds load enables
    task automatic pass_reg(input logic [2:0] r);
        idle();
        BUS_SEL = 2'd2; ALUK = 2'd3; SR1_SEL = r; LD_BUS = 1;
    endtask

    // IR = 1 so SEXT(IR[4:0]) supplies +1 for constant building
    task automatic set_ir_one();
        idle(); PCMUX_SEL = 2'd1; LD_PC = 1; cyc();
        idle(); PCMUX_SEL = 2'd0; LD_PC = 1; cyc();
        idle(); BUS_SEL = 2'd0; LD_BUS = 1; LD_IR = 1; cyc();
    endtask

    task automatic load_const(input logic [2:0] dr, input logic [15:0] val);
        idle(); LD_REG = 1; DR = dr; cyc();
        for (int i = 15; i >= 0; i--) begin
            idle(); ALUK = 2'd0; SR1_SEL = dr; SR2_SEL = dr; BUS_SEL = 2'd2;
            LD_BUS = 1; LD_REG = 1; DR = dr; cyc();
            if (val[i]) begin
                SR2MUX_SEL = 1; cyc();
            end
        end
    endtask

    initial begin
        idle(); reset_ = 1; cyc();
        // Fill memory with mem[a] = a using PC as the counter
        idle(); PCMUX_SEL = 2'd1; LD_PC = 1; cyc();
        for (int a = 0; a <= 4096; a++) begin
            idle(); BUS_SEL = 2'd0; LD_BUS = 1; LD_MAR = 1; LD_MDR = 1; LD_PC = 1;
            MIO_EN = (a > 0); RW = (a > 0); cyc();
        end
        idle(); reset_ = 1; cyc();
        chk("rst_pc", debug_pc, 16'h3000);
        chk("rst_nzp", {13'h0, nzp}, 16'h0002);
        chk("rst_dsr", dsr, 16'h8000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_r0", debug_r0, 16'h0000);
        chk("rst_r7", debug_r7, 16'h0000);
        chk("rst_mem_kept", debug_memory, 16'h0000);

        set_ir_one();
        load_const(3'd5, 16'h0FFF);
        load_const(3'd6, 16'h3001);
        pass_reg(3'd6); PCMUX_SEL = 2'd1; LD_PC = 1; cyc();
        pass_reg(3'd5); LD_IR = 1; cyc();
        chk("pc_3001", debug_pc, 16'h3001);
        chk("ir_0fff", ir, 16'h0FFF);
        idle(); ADDR1MUX_SEL = 0; ADDR2MUX_SEL = 2'd2; PCMUX_SEL = 2'd2; LD_PC = 1; cyc();
        chk("pc_wrap", debug_pc, 16'h3000);

        set_ir_one();
        load_const(3'd1, 16'h0005);
        load_const(3'd2, 16'hFFF9);
        idle(); ALUK = 2'd0; SR1_SEL = 1; SR2_SEL = 2; BUS_SEL = 2'd2; LD_BUS = 1;
        LD_REG = 1; DR = 3; LD_CC = 1; cyc();
        chk("add_r3", debug_r3, 16'hFFFE);
        chk("add_nzp", {13'h0, nzp}, 16'h0004);
        idle(); LD_IR = 1; cyc();
        idle(); ALUK = 2'd1; SR1_SEL = 3; SR2MUX_SEL = 1; BUS_SEL = 2'd2; LD_BUS = 1;
        LD_REG = 1; DR = 3; LD_CC = 1; cyc();
        chk("and_r3", debug_r3, 16'h0000);
        chk("and_nzp", {13'h0, nzp}, 16'h0002);

        set_ir_one();
        load_const(3'd1, 16'h0010);
        load_const(3'd2, 16'hBEEF);
        pass_reg(3'd1); LD_MAR = 1; cyc();
        pass_reg(3'd2); LD_MDR = 1; cyc();
        idle(); MIO_EN = 1; RW = 1; cyc();
        chk("mem_store", debug_memory, 16'hBEEF);
        idle(); LD_MDR = 1; cyc();
        chk("mdr_clear", debug_mdr, 16'h0000);
        idle(); MIO_EN = 1; RW = 0; LD_MDR = 1; #1;
        chk("ready", {15'h0, R}, 16'h0001);
        cyc();
        chk("mdr_load", debug_mdr, 16'hBEEF);

        load_const(3'd1, 16'hFE06);
        load_const(3'd2, 16'h0041);
        pass_reg(3'd1); LD_MAR = 1; cyc();
        pass_reg(3'd2); LD_MDR = 1; cyc();
        idle(); MIO_EN = 1; RW = 1; cyc();
        chk("ddr_store", ddr, 16'h0041);
        load_const(3'd1, 16'hFE04);
        pass_reg(3'd1); LD_MAR = 1; cyc();
        idle(); MIO_EN = 1; RW = 1; LD_DSR_EXT = 1; dsr_ext = 16'h0000; cyc();
        chk("dsr_ext_wins", dsr, 16'h0000);
        idle(); MIO_EN = 1; RW = 1; cyc();
        chk("dsr_store", dsr, 16'h0041);

        idle(); BUS_SEL = 2'd3; LD_BUS = 0; LD_MAR = 1; cyc();
        chk("mar_zero_bus", debug_mar, 16'h0000);
        idle(); reset_ = 1; BUS_SEL = 2'd3; LD_BUS = 1; PCMUX_SEL = 2'd1; LD_PC = 1; cyc();
        chk("rst_beats_ldpc", debug_pc, 16'h3000);

        for (int c = 0; c < 4000; c++) begin
            reset_       = ($urandom_range(0, 59) == 0);
            ALUK         = 2'($urandom);
            BUS_SEL      = 2'($urandom);
            PCMUX_SEL    = 2'($urandom);
            ADDR2MUX_SEL = 2'($urandom);
            LD_BUS       = ($urandom_range(0, 3) != 0);
            RW           = 1'($urandom);
            MIO_EN       = 1'($urandom);
            SR2MUX_SEL   = 1'($urandom);
            MARMUX_SEL   = 1'($urandom);
            ADDR1MUX_SEL = 1'($urandom);
            DR           = 3'($urandom);
            SR1_SEL      = 3'($urandom);
            SR2_SEL      = 3'($urandom);
            LD_CC        = 1'($urandom);
            LD_REG       = 1'($urandom);
            LD_IR        = 1'($urandom);
            LD_PC        = 1'($urandom);
            LD_MAR       = 1'($urandom);
            LD_MDR       = 1'($urandom);
            LD_DSR_EXT   = ($urandom_range(0, 7) == 0);
            dsr_ext      = 16'($urandom);
            cyc();
        end
        idle(); cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
